pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/cpu_pkg.sv | 12 +
 rtl/hazard_detect.sv | 37 +++
 rtl/pipe_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants and the hazard-controller FSM encoding.
package cpu_pkg;

    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard compares between ID sources and EX/MEM destinations.
module hazard_detect (
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [3:0] id_rs1,
    input  logic [3:0] id_rs2,
    input  logic       id_branch,
    input  logic       id_branch_reg,
    input  logic       ex_mem_read,
    input  logic       ex_reg_write,
    input  logic       ex_flag_write,
    input  logic [3:0] ex_rd,
    input  logic       mem_mem_read,
    input  logic [3:0] mem_rd,
    output logic       load_use,
    output logic       br_haz,
    output logic       flag_haz
);

    // Register 0 is hardwired, so a zero destination never creates a dependency.
    logic exRdLive;
    logic memRdLive;

    assign exRdLive  = (ex_rd != 4'd0);
    assign memRdLive = (mem_rd != 4'd0);

    assign load_use = ex_mem_read & ex_reg_write & exRdLive &
                      ((id_rs1_used & (id_rs1 == ex_rd)) |
                       (id_rs2_used & (id_rs2 == ex_rd)));

    assign br_haz = id_branch_reg &
                    ((ex_reg_write & exRdLive & (id_rs1 == ex_rd)) |
                     (mem_mem_read & memRdLive & (id_rs1 == mem_rd)));

    assign flag_haz = id_branch & ex_flag_write;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller with HLT drain sequencing and a saturating stall counter.
module pipe_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       id_opcode,
    input  logic [3:0]       id_rs1,
    input  logic [3:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             id_branch,
    input  logic             id_branch_reg,
    input  logic             id_branch_take,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic             ex_flag_write,
    input  logic [3:0]       ex_rd,
    input  logic             mem_mem_read,
    input  logic [3:0]       mem_rd,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    state_t        state;
    state_t        stateNext;
    logic [DW-1:0] drainCnt;
    logic [DW-1:0] drainCntNext;
    logic          stallInc;
    logic          loadUse;
    logic          brHaz;
    logic          flagHaz;
    logic          anyHaz;

    hazard_detect u_hazard_detect (
        .id_rs1_used   (id_rs1_used),
        .id_rs2_used   (id_rs2_used),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_branch     (id_branch),
        .id_branch_reg (id_branch_reg),
        .ex_mem_read   (ex_mem_read),
        .ex_reg_write  (ex_reg_write),
        .ex_flag_write (ex_flag_write),
        .ex_rd         (ex_rd),
        .mem_mem_read  (mem_mem_read),
        .mem_rd        (mem_rd),
        .load_use      (loadUse),
        .br_haz        (brHaz),
        .flag_haz      (flagHaz)
    );

    assign anyHaz = loadUse | brHaz | flagHaz;

    // State, drain countdown and saturating stall statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            drainCnt  <= '0;
            stall_cnt <= '0;
        end else begin
            state    <= stateNext;
            drainCnt <= drainCntNext;
            if (stallInc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state and pipeline control; a held reset presents free-running enables.
    always_comb begin
        stateNext    = state;
        drainCntNext = drainCnt;
        stallInc     = 1'b0;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        halted       = 1'b0;
        if (rst_n) begin
            unique case (state)
                ST_RUN: begin
                    if (anyHaz) begin
                        // A coincident taken branch is dropped here and re-resolved next cycle.
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                        stallInc    = 1'b1;
                    end else if (id_opcode == OP_HLT) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        if_id_flush  = 1'b1;
                        stateNext    = ST_DRAIN;
                        drainCntNext = DRAIN_LOAD;
                    end else if (id_branch_take) begin
                        if_id_flush = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (drainCnt == '0) begin
                        stateNext = ST_HALTED;
                    end else begin
                        drainCntNext = drainCnt - DW'(1);
                    end
                end
                ST_HALTED: begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    halted      = 1'b1;
                end
                default: begin
                    stateNext = ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed corner cases then randomized traffic.
module tb_pipe_hazard_ctrl;

    localparam int unsigned DRAIN = 3;
    localparam int unsigned CW    = 4;

    typedef struct {
        logic [3:0] opcode;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic       rs1Used;
        logic       rs2Used;
        logic       branch;
        logic       branchReg;
        logic       branchTake;
        logic       exMemRead;
        logic       exRegWrite;
        logic       exFlagWrite;
        logic [3:0] exRd;
        logic       memMemRead;
        logic [3:0] memRd;
    } stim_t;

    typedef struct {
        logic          pcEn;
        logic          ifIdEn;
        logic          ifIdFlush;
        logic          idExFlush;
        logic          halted;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] id_opcode, id_rs1, id_rs2, ex_rd, mem_rd;
    logic id_rs1_used, id_rs2_used, id_branch, id_branch_reg, id_branch_take;
    logic ex_mem_read, ex_reg_write, ex_flag_write, mem_mem_read;
    logic pc_en, if_id_en, if_id_flush, id_ex_flush, halted;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;
    exp_t expQ[$];

    // Reference model: cycles elapsed since HLT was accepted (-1: none), plus stall tally.
    int sinceHlt = -1;
    int mCnt     = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_branch(id_branch), .id_branch_reg(id_branch_reg), .id_branch_take(id_branch_take),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_flag_write(ex_flag_write),
        .ex_rd(ex_rd), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .halted(halted), .stall_cnt(stall_cnt)
    );

    function automatic stim_t idle();
        stim_t s;
        s = '{opcode: 4'h0, rs1: 4'h0, rs2: 4'h0, rs1Used: 1'b0, rs2Used: 1'b0,
              branch: 1'b0, branchReg: 1'b0, branchTake: 1'b0, exMemRead: 1'b0,
              exRegWrite: 1'b0, exFlagWrite: 1'b0, exRd: 4'h0, memMemRead: 1'b0, memRd: 4'h0};
        return s;
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        s.opcode      = ($urandom_range(0, 59) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        s.rs1         = 4'($urandom_range(0, 3));
        s.rs2         = 4'($urandom_range(0, 3));
        s.rs1Used     = 1'($urandom_range(0, 1));
        s.rs2Used     = 1'($urandom_range(0, 1));
        s.branchReg   = ($urandom_range(0, 3) == 0);
        s.branch      = s.branchReg | ($urandom_range(0, 3) == 0);
        s.branchTake  = s.branch & 1'($urandom_range(0, 1));
        s.exMemRead   = ($urandom_range(0, 3) == 0);
        s.exRegWrite  = 1'($urandom_range(0, 1));
        s.exFlagWrite = ($urandom_range(0, 4) == 0);
        s.exRd        = 4'($urandom_range(0, 3));
        s.memMemRead  = ($urandom_range(0, 3) == 0);
        s.memRd       = 4'($urandom_range(0, 3));
        return s;
    endfunction

    // True when the instruction in ID depends on a result not yet available.
    function automatic bit mustWait(input stim_t s);
        bit srcHitsEx;
        bit lu, br, fl;
        srcHitsEx = (s.rs1Used && s.rs1 == s.exRd) || (s.rs2Used && s.rs2 == s.exRd);
        lu = s.exMemRead && s.exRegWrite && s.exRd != 0 && srcHitsEx;
        br = s.branchReg && ((s.exRegWrite && s.exRd != 0 && s.rs1 == s.exRd) ||
                             (s.memMemRead && s.memRd != 0 && s.rs1 == s.memRd));
        fl = s.branch && s.exFlagWrite;
        return lu || br || fl;
    endfunction

    // Apply one cycle of stimulus and queue what the controller must present in it.
    task automatic step(input stim_t s, input bit rstLow);
        exp_t e;
        @(posedge clk);
        #1;
        id_opcode = s.opcode; id_rs1 = s.rs1; id_rs2 = s.rs2;
        id_rs1_used = s.rs1Used; id_rs2_used = s.rs2Used;
        id_branch = s.branch; id_branch_reg = s.branchReg; id_branch_take = s.branchTake;
        ex_mem_read = s.exMemRead; ex_reg_write = s.exRegWrite; ex_flag_write = s.exFlagWrite;
        ex_rd = s.exRd; mem_mem_read = s.memMemRead; mem_rd = s.memRd;
        rst_n = ~rstLow;
        if (rstLow) begin
            sinceHlt = -1;
            mCnt = 0;
            e = '{pcEn: 1'b1, ifIdEn: 1'b1, ifIdFlush: 1'b0, idExFlush: 1'b0, halted: 1'b0, cnt: '0};
        end else begin
            if (sinceHlt >= 0) sinceHlt++;
            e.cnt = CW'(mCnt);
            e.halted = 1'b0;
            if (sinceHlt > int'(DRAIN)) begin
                e.pcEn = 0; e.ifIdEn = 0; e.ifIdFlush = 1; e.idExFlush = 1; e.halted = 1;
            end else if (sinceHlt >= 1) begin
                e.pcEn = 0; e.ifIdEn = 0; e.ifIdFlush = 1; e.idExFlush = 1;
            end else if (mustWait(s)) begin
                e.pcEn = 0; e.ifIdEn = 0; e.ifIdFlush = 0; e.idExFlush = 1;
                if (mCnt < (1 << CW) - 1) mCnt++;
            end else if (s.opcode == 4'hF) begin
                e.pcEn = 0; e.ifIdEn = 0; e.ifIdFlush = 1; e.idExFlush = 0;
                sinceHlt = 0;
            end else begin
                e.pcEn = 1; e.ifIdEn = 1; e.ifIdFlush = s.branchTake; e.idExFlush = 0;
            end
        end
        expQ.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checks++;
                if ({pc_en, if_id_en, if_id_flush, id_ex_flush, halted, stall_cnt} !==
                    {e.pcEn, e.ifIdEn, e.ifIdFlush, e.idExFlush, e.halted, e.cnt}) begin
                    errors++;
                    $display("FAIL ctrl t=%0t got pc=%b ifid=%b iff=%b ief=%b hlt=%b cnt=%h want pc=%b ifid=%b iff=%b ief=%b hlt=%b cnt=%h",
                             $time, pc_en, if_id_en, if_id_flush, id_ex_flush, halted, stall_cnt,
                             e.pcEn, e.ifIdEn, e.ifIdFlush, e.idExFlush, e.halted, e.cnt);
                end
            end
        end
    end

    initial begin
        stim_t s;
        stim_t h;
        int waitCyc;
        rst_n = 1'b0;
        s = idle();
        id_opcode = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_branch = 0; id_branch_reg = 0; id_branch_take = 0; ex_mem_read = 0;
        ex_reg_write = 0; ex_flag_write = 0; ex_rd = 0; mem_mem_read = 0; mem_rd = 0;

        // Reset held with a live load-use pattern: enables must stay free-running.
        s.exMemRead = 1; s.exRegWrite = 1; s.exRd = 3; s.rs2Used = 1; s.rs2 = 3;
        step(s, 1'b1);
        step(s, 1'b1);
        step(idle(), 1'b0);

        // Single load-use stall, then the same with rd=0.
        step(s, 1'b0);
        step(idle(), 1'b0);
        s.exRd = 0; s.rs2 = 0;
        step(s, 1'b0);
        step(idle(), 1'b0);

        // Flag hazard swallowing a taken branch, then the branch flushes once.
        s = idle(); s.branch = 1; s.exFlagWrite = 1; s.branchTake = 1;
        step(s, 1'b0);
        s.exFlagWrite = 0;
        step(s, 1'b0);
        step(idle(), 1'b0);

        // Saturate the narrow counter.
        s = idle(); s.exMemRead = 1; s.exRegWrite = 1; s.exRd = 3; s.rs1Used = 1; s.rs1 = 3;
        for (int i = 0; i < 20; i++) step(s, 1'b0);
        step(idle(), 1'b0);

        // HLT, reset during drain, then a full halt with hazards present.
        h = idle(); h.opcode = 4'hF;
        step(h, 1'b0);
        step(idle(), 1'b0);
        step(idle(), 1'b1);
        step(idle(), 1'b0);
        step(h, 1'b0);
        for (int i = 0; i < 8; i++) step(randStim(), 1'b0);
        step(idle(), 1'b1);

        // Random traffic; recover from halt after a short dwell.
        for (int i = 0; i < 3000; i++) begin
            step(randStim(), (sinceHlt > int'(DRAIN) + 4) || ($urandom_range(0, 199) == 0));
        end

        waitCyc = 0;
        while (expQ.size() != 0 && waitCyc < 10) begin
            @(posedge clk);
            waitCyc++;
        end
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain_queue left=%0d want 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
